blinky_led: RTL and testbench
=============================

// Module: blinky_led
//
// PURPOSE
// Free-running LED blinker: divides the system clock by a programmable
// half-period and toggles a single LED output, giving a 50% duty square
// wave. First bring-up block of the design, used as a visible heartbeat.
// Also exports a completed-blink counter and a toggle strobe for status.
//
// PARAMETERS
// HALF_PERIOD  4   clock cycles per LED level (on time = off time); >= 1
// CNT_W        16  width of internal divider counter; 2**CNT_W > HALF_PERIOD
// BLINK_W      8   width of blink_cnt output counter
//
// PORTS
// clk        in   1        system clock, rising-edge active
// rst_n      in   1        asynchronous active-low reset
// en         in   1        1 = run divider, 0 = freeze divider and LED state
// led        out  1        LED drive, 1 = lit; registered
// tick       out  1        1-cycle strobe, high in the cycle led changes level
// blink_cnt  out  BLINK_W  number of completed blinks (led 1->0), wraps
//
// BEHAVIOUR
// - One clock domain. Reset is asynchronous and active-low.
// - While rst_n=0: led=0, tick=0, blink_cnt=0, divider cnt=0.
// - All outputs are registered; no combinational path from input to output.
// - Divider: cnt counts 0..HALF_PERIOD-1 on each rising clk edge with en=1.
//   - Edge with en=1 and cnt==HALF_PERIOD-1: cnt<=0, led<=~led, tick<=1.
//   - Any other edge with en=1: cnt<=cnt+1, tick<=0.
//   - Edge with en=0: cnt and led hold, tick<=0, blink_cnt holds.
// - After reset release with en=1, led first goes 1 on the HALF_PERIOD-th
//   rising edge, then toggles every HALF_PERIOD edges.
//   Full blink period = 2*HALF_PERIOD cycles.
// - HALF_PERIOD=1: led toggles every enabled edge, tick stays high.
// - blink_cnt increments on the edge where led goes 1->0, same edge as the
//   tick. Wraps from 2**BLINK_W-1 to 0 with no flag.
// - en toggling mid-period: the partial count is kept. Phase resumes where
//   it stopped; the period is stretched by the number of disabled cycles.
// - rst_n asserted mid-period: everything clears at once, asynchronously.
//   The count restarts from 0 on the first edge after release.
// - rst_n is released synchronously to clk by the system. The block adds
//   no reset synchronizer.
//
// TESTING
// - Reset: rst_n=0 for 3 edges -> led=0, tick=0, blink_cnt=0, even
//   with en=1.
// - Default run: HALF_PERIOD=4, 2 ns clk, en=1, 160 ns -> 20 led
//   toggles, led rises at edges 4,12,20..., blink_cnt=10 at the end.
// - tick: pulses exactly once per toggle. High one cycle at edges
//   4,8,12,... and low elsewhere.
// - Enable gating: en=0 for 5 cycles after edge 2 -> first rise moves to
//   edge 9, no tick while en=0.
// - Reset mid-operation: rst_n=0 at edge 6 (led=1) -> led=0 at once.
//   Next rise is 4 edges after release.
// - Wrap and corners: BLINK_W=2, run 5 blinks -> blink_cnt 1,2,3,0,1.
//   HALF_PERIOD=1 -> led toggles every edge.

Source files
------------

// File: rtl/blinky_led.sv
// Free-running LED heartbeat: divides clk by HALF_PERIOD and toggles led,
// with a one-cycle toggle strobe and a wrapping completed-blink counter.
module blinky_led #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned BLINK_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               led,
  output logic               tick,
  output logic [BLINK_W-1:0] blink_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  // A disabled edge holds the partial count, so the period stretches by the
  // number of disabled cycles instead of losing phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      led       <= 1'b0;
      tick      <= 1'b0;
      blink_cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        led  <= ~led;
        tick <= 1'b1;
        if (led)
          blink_cnt <= blink_cnt + 1'b1;
      end else begin
        cnt  <= cnt + 1'b1;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_blinky_led.sv
// Scoreboard bench for blinky_led: one instance at HALF_PERIOD=4/BLINK_W=8,
// one at HALF_PERIOD=1/BLINK_W=2, sharing clk, rst_n and en.
module tb_blinky_led;

  localparam int HP0 = 4;
  localparam int HP1 = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       led0, tick0, led1, tick1;
  logic [7:0] bc0;
  logic [1:0] bc1;

  blinky_led #(.HALF_PERIOD(4), .CNT_W(16), .BLINK_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .led(led0), .tick(tick0), .blink_cnt(bc0)
  );

  blinky_led #(.HALF_PERIOD(1), .CNT_W(4), .BLINK_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .led(led1), .tick(tick1), .blink_cnt(bc1)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    logic       led0, tick0;
    logic [7:0] c0;
    logic       led1, tick1;
    logic [1:0] c1;
    bit         hv;
    logic       hled, htick;
    bit         wv;
    logic [1:0] wcnt;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   k0 = 0, k1 = 0;
  int   edge_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, then push what the outputs must be after that edge.
  // Expected values come from the number of enabled edges since reset.
  task automatic step(input logic r, input logic e,
                      input bit hv = 1'b0, input logic hled = 1'b0, input logic htick = 1'b0,
                      input bit wv = 1'b0, input logic [1:0] wcnt = 2'd0);
    exp_t x;
    logic t0, t1;
    @(negedge clk);
    rst_n = r;
    en    = e;
    @(posedge clk);
    edge_no++;
    if (!r) begin
      k0 = 0; k1 = 0; t0 = 1'b0; t1 = 1'b0;
    end else if (e) begin
      k0++; k1++;
      t0 = (k0 % HP0 == 0);
      t1 = (k1 % HP1 == 0);
    end else begin
      t0 = 1'b0; t1 = 1'b0;
    end
    x.edge_no = edge_no;
    x.led0  = 1'((k0 / HP0) % 2);
    x.tick0 = t0;
    x.c0    = 8'((k0 / HP0 / 2) % 256);
    x.led1  = 1'((k1 / HP1) % 2);
    x.tick1 = t1;
    x.c1    = 2'((k1 / HP1 / 2) % 4);
    x.hv = hv; x.hled = hled; x.htick = htick;
    x.wv = wv; x.wcnt = wcnt;
    q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        check("led0", 32'(led0), 32'(x.led0));
        check("tick0", 32'(tick0), 32'(x.tick0));
        check("blink_cnt0", 32'(bc0), 32'(x.c0));
        check("led1", 32'(led1), 32'(x.led1));
        check("tick1", 32'(tick1), 32'(x.tick1));
        check("blink_cnt1", 32'(bc1), 32'(x.c1));
        if (x.hv) begin
          check("hand_led0", 32'(led0), 32'(x.hled));
          check("hand_tick0", 32'(tick0), 32'(x.htick));
        end
        if (x.wv)
          check("hand_wrap1", 32'(bc1), 32'(x.wcnt));
      end
    end
  end

  initial begin : stimulus
    logic [1:0] wrap_tbl [10];
    int         drain;
    wrap_tbl = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1};

    // Reset held with en=1 for three edges
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Default run: 80 edges; led high at 4..7, 12..15, 20..23
    edge_no = 0;
    for (int i = 1; i <= 80; i++) begin
      if (i <= 24)
        step(1'b1, 1'b1, 1'b1,
             (i inside {[4:7], [12:15], [20:23]}),
             (i inside {4, 8, 12, 16, 20, 24}));
      else
        step(1'b1, 1'b1);
    end
    @(negedge clk);
    check("run_blink_cnt0", 32'(bc0), 32'd10);
    check("run_led0", 32'(led0), 32'd0);

    // Enable gating: en low on edges 3..7, first rise moves to edge 9
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    edge_no = 0;
    for (int i = 1; i <= 12; i++)
      step(1'b1, !(i inside {[3:7]}), 1'b1, (i >= 9), (i == 9));

    // Mid-operation asynchronous reset while led is lit
    step(1'b0, 1'b1);
    edge_no = 0;
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b1, 1'b1, (i >= 4), (i == 4));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_led0", 32'(led0), 32'd0);
    check("async_blink_cnt1", 32'(bc1), 32'd0);
    check("async_led1", 32'(led1), 32'd0);
    k0 = 0; k1 = 0;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    edge_no = 0;
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 1'b1, (i >= 4), (i == 4));

    // Two-bit blink counter wrap at HALF_PERIOD=1: 1,2,3,0,1
    step(1'b0, 1'b1);
    edge_no = 0;
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, wrap_tbl[i]);

    drain = 0;
    while (q.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
